reset_sequencer: RTL

- Sequences the per-subsystem synchronous resets after a board reset or a software reset request.
- All stage resets are held for a fixed stretch, then released one stage at a time. Each stage must acknowledge (e.g. clock locked, calibration done) before the next is released.
- Sits beside the reset-state flag logic at the top of the design and drives the reset inputs of the clocking, ADC/DAC and processing subsystems.

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/seq_timer.sv | 47 ++++
 rtl/reset_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings,
// default timing parameters, counter widths and a saturating-increment helper.
package reset_seq_pkg;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  // Default timing
  localparam int DEF_HOLD_CYCLES = 8;
  localparam int DEF_ACK_TIMEOUT = 100;

  // Widths of the status outputs
  localparam int RESTART_CNT_W = 8;
  localparam int IDX_W         = 3;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [RESTART_CNT_W-1:0] sat_inc(input logic [RESTART_CNT_W-1:0] v);
    if (v == {RESTART_CNT_W{1'b1}}) begin
      return v;
    end
    return v + RESTART_CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable up-counter with clear, enable and a terminal-count compare.
// Shared by the HOLD stretch and the per-stage acknowledge timeout; the
// caller selects the terminal value for the phase it is in.
module seq_timer
  import reset_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load, load beats enable, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is judged on the registered value so the FSM acts on the
  // cycle in which the count reaches the limit.
  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all subsystem resets for HOLD_CYCLES, then
// releases them one stage at a time, waiting for each stage to acknowledge
// before releasing the next. A missing acknowledge within ACK_TIMEOUT
// cycles parks the sequencer in ERROR until sw_rst_req or rst.
// Optional build macro: RESET_SEQ_ACK_MONITOR_EN -- in DONE, an ack bit
// low for two consecutive samples restarts the sequence and sets ack_lost.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sw_rst_req,
  input  logic [N_STAGES-1:0]      stage_ack,
  output logic [N_STAGES-1:0]      stage_rst,
  output logic                     seq_done,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [IDX_W-1:0]         fail_stage,
`ifdef RESET_SEQ_ACK_MONITOR_EN
  output logic                     ack_lost,
`endif
  output logic [RESTART_CNT_W-1:0] restart_cnt
);

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_TC  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  state_t                   state_q,       state_d;
  logic [IDX_W-1:0]         idx_q,         idx_d;
  logic [N_STAGES-1:0]      stage_rst_q,   stage_rst_d;
  logic                     seq_done_q,    seq_done_d;
  logic                     busy_q,        busy_d;
  logic                     timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]         fail_stage_q,  fail_stage_d;
  logic [RESTART_CNT_W-1:0] restart_cnt_q, restart_cnt_d;

  logic                     tmr_clr;
  logic                     tmr_en;
  logic                     tmr_tc;
  logic [CNT_W-1:0]         tmr_tc_val;

  logic                     ack_cur;
  logic                     idx_is_last;
  logic [N_STAGES-1:0]      next_sel;
  logic [N_STAGES-1:0]      at_or_above;
  logic                     ack_lost_evt;

  // Terminal value depends on the phase; outside HOLD/WAIT_ACK the timer is idle
  assign tmr_tc_val = (state_q == ST_HOLD) ? HOLD_TC : ACK_TC;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .tc_val   (tmr_tc_val),
    .tc       (tmr_tc)
  );

  // Per-stage decode of the current index: the stage to release next and
  // the stages to re-assert if the current one times out.
  genvar gi;
  generate
    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage_sel
      assign next_sel[gi]    = (IDX_W'(gi) == (idx_q + IDX_W'(1)));
      assign at_or_above[gi] = (IDX_W'(gi) >= idx_q);
    end
  endgenerate

  assign idx_is_last = (idx_q == LAST_IDX);

  // Select the acknowledge of the stage currently being waited on
  always_comb begin
    ack_cur = 1'b0;
    for (int i = 0; i < N_STAGES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        ack_cur = stage_ack[i];
      end
    end
  end

`ifdef RESET_SEQ_ACK_MONITOR_EN
  logic [N_STAGES-1:0] mon_low_q, mon_low_d;
  logic                ack_lost_q, ack_lost_d;

  // Remember which acks were low on the previous DONE cycle; a bit low on
  // two consecutive DONE samples means that subsystem lost its ready.
  always_comb begin
    mon_low_d    = '0;
    ack_lost_evt = 1'b0;
    ack_lost_d   = ack_lost_q;
    if (state_q == ST_DONE) begin
      mon_low_d    = ~stage_ack;
      ack_lost_evt = |(mon_low_q & ~stage_ack);
    end
    if (ack_lost_evt) begin
      ack_lost_d = 1'b1;
    end
  end

  // Monitor history and sticky flag; only rst clears ack_lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_low_q  <= '0;
      ack_lost_q <= 1'b0;
    end else begin
      mon_low_q  <= mon_low_d;
      ack_lost_q <= ack_lost_d;
    end
  end

  assign ack_lost = ack_lost_q;
`else
  assign ack_lost_evt = 1'b0;
`endif

  // Sequencing FSM and next values of all registered outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    seq_done_d    = seq_done_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    fail_stage_d  = fail_stage_q;
    restart_cnt_d = restart_cnt_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (tmr_tc) begin
          state_d        = ST_WAIT_ACK;
          idx_d          = '0;
          tmr_clr        = 1'b1;
          stage_rst_d[0] = 1'b0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // Ack wins over a timeout landing on the same cycle
        if (ack_cur) begin
          tmr_clr = 1'b1;
          if (idx_is_last) begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            stage_rst_d = stage_rst_q & ~next_sel;
          end
        end else if (tmr_tc) begin
          // Stages below idx are already acknowledged and stay released
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
          fail_stage_d  = idx_q;
          stage_rst_d   = stage_rst_q | at_or_above;
          busy_d        = 1'b0;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
      end
      ST_ERROR: begin
      end
      default: begin
      end
    endcase

    // A restart request overrides whatever the current state decided
    if (sw_rst_req || ack_lost_evt) begin
      state_d       = ST_HOLD;
      idx_d         = '0;
      tmr_clr       = 1'b1;
      tmr_en        = 1'b0;
      stage_rst_d   = '1;
      seq_done_d    = 1'b0;
      busy_d        = 1'b1;
      timeout_err_d = 1'b0;
      if (sw_rst_req) begin
        restart_cnt_d = sat_inc(restart_cnt_q);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      seq_done_q    <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
      fail_stage_q  <= '0;
      restart_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      seq_done_q    <= seq_done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      fail_stage_q  <= fail_stage_d;
      restart_cnt_q <= restart_cnt_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign seq_done    = seq_done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign fail_stage  = fail_stage_q;
  assign restart_cnt = restart_cnt_q;

endmodule
